// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data responder and its store buffer.
// Sizes and the entry field widths live here so cpu/computer can import the same values.
package data_mem_responder_pkg;

  localparam int DMEM_ADDR_W   = 8;
  localparam int DMEM_SB_DEPTH = 4;
  localparam int DMEM_DATA_W   = 32;

  localparam int SB_ENTRY_ADDR_W = DMEM_ADDR_W;
  localparam int SB_ENTRY_DATA_W = DMEM_DATA_W;

  // The buffer has no state machine of its own; these are the occupancy classes implied by count.
  typedef enum logic [1:0] {
    SB_EMPTY   = 2'd0,
    SB_PARTIAL = 2'd1,
    SB_FULL    = 2'd2
  } sb_occ_e;

  function automatic sb_occ_e occ_of(input int unsigned cnt, input int unsigned depth);
    sb_occ_e occ;
    if (cnt == 0) begin
      occ = SB_EMPTY;
    end else if (cnt >= depth) begin
      occ = SB_FULL;
    end else begin
      occ = SB_PARTIAL;
    end
    return occ;
  endfunction

endpackage

// File: rtl/data_mem_responder_store_buffer_fifo.sv
// Store buffer: circular FIFO of {word addr, data} with a parallel address match port.
// Matching looks only at registered entries, so a store pushed this cycle is invisible until next cycle.
module store_buffer_fifo
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = SB_ENTRY_ADDR_W,
  parameter int DATA_W = SB_ENTRY_DATA_W,
  parameter int DEPTH  = DMEM_SB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] match_addr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output sb_occ_e           occ,
  output logic              sb_empty,
  output logic              match_hit,
  output logic [DATA_W-1:0] match_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] entry_addr_q [DEPTH];
  logic [DATA_W-1:0] entry_data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sb_empty_q, sb_empty_d;
  logic [PTR_W-1:0] idx;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    sb_empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      sb_empty_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      sb_empty_q <= sb_empty_d;
    end
  end

  // Entry storage carries no reset; validity comes purely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr_q[tail_q] <= push_addr;
      entry_data_q[tail_q] <= push_data;
    end
  end

  // Walk oldest to youngest so the last hit assigned is the youngest matching entry.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (entry_addr_q[idx] == match_addr)) begin
        match_hit  = 1'b1;
        match_data = entry_data_q[idx];
      end
    end
  end

  assign head_addr = entry_addr_q[head_q];
  assign head_data = entry_data_q[head_q];
  assign occ       = occ_of(32'(count_q), 32'(DEPTH));
  assign sb_empty  = sb_empty_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data responder: posts stores into a small buffer, drains them into the word array on
// load-free cycles, and answers loads combinationally with store-to-load forwarding.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int SB_DEPTH = DMEM_SB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        stall,
  output logic        sb_empty
);

  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  logic [31:0]       match_data;
  logic              match_hit;
  sb_occ_e           occ;
  logic              full;
  logic              drain;
  logic              accept;
  logic              mem_we;
  logic              unused_addr_bits;

  logic [31:0] mem_q [2**ADDR_W];

  assign word_addr        = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign full   = (occ == SB_FULL);
  assign drain  = (occ != SB_EMPTY) & ~r_en;
  assign stall  = w_en & full & ~drain;
  assign accept = w_en & ~stall;
  // A drain coinciding with reset is dropped along with the rest of the buffer.
  assign mem_we = drain & ~rst;

  store_buffer_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (32),
    .DEPTH  (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_addr  (word_addr),
    .push_data  (w_data),
    .pop        (drain),
    .match_addr (word_addr),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .occ        (occ),
    .sb_empty   (sb_empty),
    .match_hit  (match_hit),
    .match_data (match_data)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[head_addr] <= head_data;
    end
  end

  assign r_data = match_hit ? match_data : mem_q[word_addr];

endmodule
